io_clk_sequencer: RTL and testbench

IO_CLK_SEQUENCER -- requirements
Module: io_clk_sequencer

---
 rtl/io_clk_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_io_clk_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_clk_sequencer.sv
// ---------------------------------------------------------------------------
// io_clk_sequencer
//
// Purpose:
//   Controls a link's clock generation and recovery path. It accepts
//   START / PAUSE_SHORT / PAUSE_LONG / STOP commands and tracks the clock
//   lock and pause-complete status from the clock path. Violation pulses
//   from clock recovery move it to a FAULT state that records the cause.
//   All enables and status flags are registered. They are loaded from the
//   next-state value, so each one changes on the same edge as state_o.
//
// Optional feature (macro IO_CLK_SEQ_WATCHDOG_EN):
//   When defined, a 16-bit saturating watchdog counter limits how long the
//   FSM may stay in LOCKING/STOPPING (Lock_Timeout) and in PAUSING
//   (Pause_Timeout). On expiry the FSM enters FAULT with code 01.
//   When the macro is not defined, the counter is absent and those states
//   wait indefinitely.
//
// Parameters:
//   Lock_Timeout   cycles allowed in LOCKING/STOPPING   (2..65535)
//   Pause_Timeout  cycles allowed in PAUSING            (2..65535)
//
// Ports:
//   clk_i                       clock, rising edge
//   rst_n_i                     asynchronous active-low reset
//   cmd_valid_i / cmd_i[1:0]    command offer (00 START, 01 PAUSE_SHORT,
//                               10 PAUSE_LONG, 11 STOP)
//   cmd_ready_o                 combinational; a command is taken when
//                               valid and ready are both high
//   clk_lock_i                  clock path is locked
//   short/long_pause_complete_i pause-done pulses
//   frequency/data_overflow/data_underflow_violation_i  violation pulses
//   fault_clear_i               leaves FAULT
//   generation/recovery/pause_enable_o  registered clock-path enables
//   ready_o, fault_o            link active / in FAULT
//   fault_code_o[1:0]           00 none, 01 timeout, 10 frequency, 11 data
//   cmd_error_o                 one-cycle pulse after an illegal command
//   state_o[2:0]                current state encoding
// ---------------------------------------------------------------------------
module io_clk_sequencer #(
    parameter int unsigned Lock_Timeout  = 1024,
    parameter int unsigned Pause_Timeout = 4096
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_i,
    output logic       cmd_ready_o,
    input  logic       clk_lock_i,
    input  logic       short_pause_complete_i,
    input  logic       long_pause_complete_i,
    input  logic       frequency_violation_i,
    input  logic       data_overflow_violation_i,
    input  logic       data_underflow_violation_i,
    input  logic       fault_clear_i,
    output logic       generation_enable_o,
    output logic       recovery_enable_o,
    output logic       pause_enable_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o,
    output logic       cmd_error_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_LOCKING  = 3'b001,
        ST_ACTIVE   = 3'b010,
        ST_PAUSING  = 3'b011,
        ST_STOPPING = 3'b100,
        ST_FAULT    = 3'b101
    } state_e;

    localparam logic [1:0] CMD_START       = 2'b00;
    localparam logic [1:0] CMD_PAUSE_SHORT = 2'b01;
    localparam logic [1:0] CMD_PAUSE_LONG  = 2'b10;
    localparam logic [1:0] CMD_STOP        = 2'b11;

    localparam logic [1:0] CODE_NONE      = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT   = 2'b01;
    localparam logic [1:0] CODE_FREQUENCY = 2'b10;
    localparam logic [1:0] CODE_DATA      = 2'b11;

    state_e     state_q, state_d;
    logic       pause_long_q, pause_long_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       cmd_error_q, cmd_error_d;
    logic       gen_en_q, gen_en_d;
    logic       rec_en_q, rec_en_d;
    logic       pause_en_q, pause_en_d;
    logic       ready_q, ready_d;
    logic       fault_q, fault_d;

    logic       cmd_accept;
    logic       any_violation;
    logic       pause_done;
    logic       timeout;
    logic [1:0] entry_code;

    assign cmd_accept    = cmd_valid_i & cmd_ready_o;
    assign any_violation = frequency_violation_i | data_overflow_violation_i
                         | data_underflow_violation_i;
    // Only the complete pulse that matches the latched length ends the pause.
    assign pause_done    = pause_long_q ? long_pause_complete_i
                                        : short_pause_complete_i;

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef IO_CLK_SEQ_WATCHDOG_EN
    localparam logic [15:0] LockLimit  = 16'(Lock_Timeout - 1);
    localparam logic [15:0] PauseLimit = 16'(Pause_Timeout - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        wdog_counting;

    assign wdog_counting = (state_q == ST_LOCKING) || (state_q == ST_PAUSING)
                        || (state_q == ST_STOPPING);

    // Restart on every state change so each visit gets the full budget.
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (wdog_counting && (wdog_q != 16'hFFFF)) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_comb begin
        timeout = 1'b0;
        case (state_q)
            ST_LOCKING, ST_STOPPING: timeout = (wdog_q >= LockLimit);
            ST_PAUSING:              timeout = (wdog_q >= PauseLimit);
            default:                 timeout = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // No watchdog: the timeout parameters only exist for interface
    // compatibility, and timeouts never fire.
    logic unused_timeout_params;
    assign unused_timeout_params = ^{Lock_Timeout, Pause_Timeout};
    assign timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pause_long_q <= 1'b0;
            fault_code_q <= CODE_NONE;
            cmd_error_q  <= 1'b0;
            gen_en_q     <= 1'b0;
            rec_en_q     <= 1'b0;
            pause_en_q   <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pause_long_q <= pause_long_d;
            fault_code_q <= fault_code_d;
            cmd_error_q  <= cmd_error_d;
            gen_en_q     <= gen_en_d;
            rec_en_q     <= rec_en_d;
            pause_en_q   <= pause_en_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pause_long_d = pause_long_q;
        cmd_error_d  = 1'b0;
        entry_code   = CODE_TIMEOUT;
        fault_code_d = fault_code_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_i == CMD_START) begin
                        state_d = ST_LOCKING;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end

            ST_LOCKING: begin
                if (cmd_accept && (cmd_i == CMD_STOP)) begin
                    state_d = ST_STOPPING;
                end else begin
                    // An illegal command is only flagged. It does not block
                    // the lock or timeout transitions.
                    cmd_error_d = cmd_accept;
                    if (clk_lock_i) begin
                        state_d = ST_ACTIVE;
                    end else if (timeout) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_ACTIVE: begin
                // STOP and PAUSE are legal here even when a violation wins the
                // cycle. Only START counts as an error.
                cmd_error_d = cmd_accept && (cmd_i == CMD_START);
                if (any_violation) begin
                    state_d    = ST_FAULT;
                    entry_code = frequency_violation_i ? CODE_FREQUENCY : CODE_DATA;
                end else if (cmd_accept && (cmd_i == CMD_STOP)) begin
                    state_d = ST_STOPPING;
                end else if (cmd_accept && ((cmd_i == CMD_PAUSE_SHORT) ||
                                            (cmd_i == CMD_PAUSE_LONG))) begin
                    state_d      = ST_PAUSING;
                    pause_long_d = (cmd_i == CMD_PAUSE_LONG);
                end else if (!clk_lock_i) begin
                    state_d = ST_LOCKING;
                end
            end

            ST_PAUSING: begin
                if (any_violation) begin
                    state_d    = ST_FAULT;
                    entry_code = frequency_violation_i ? CODE_FREQUENCY : CODE_DATA;
                end else if (pause_done) begin
                    state_d = ST_ACTIVE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end

            ST_STOPPING: begin
                if (!clk_lock_i) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end

            ST_FAULT: begin
                if (fault_clear_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                // Unused encodings fall back to IDLE.
                state_d = ST_IDLE;
            end
        endcase

        // The cause is captured on entry, held while in FAULT and cleared on exit.
        if (state_d == ST_FAULT) begin
            if (state_q != ST_FAULT) begin
                fault_code_d = entry_code;
            end
        end else begin
            fault_code_d = CODE_NONE;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOCKING)
                   || (state_q == ST_ACTIVE);
        gen_en_d    = (state_d == ST_LOCKING) || (state_d == ST_ACTIVE)
                   || (state_d == ST_PAUSING);
        rec_en_d    = (state_d == ST_ACTIVE) || (state_d == ST_PAUSING);
        pause_en_d  = (state_d == ST_PAUSING);
        ready_d     = (state_d == ST_ACTIVE);
        fault_d     = (state_d == ST_FAULT);
    end

    assign generation_enable_o = gen_en_q;
    assign recovery_enable_o   = rec_en_q;
    assign pause_enable_o      = pause_en_q;
    assign ready_o             = ready_q;
    assign fault_o             = fault_q;
    assign fault_code_o        = fault_code_q;
    assign cmd_error_o         = cmd_error_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_io_clk_sequencer.sv
// Testbench for io_clk_sequencer: directed scenarios plus a randomized run
// checked against a cycle-level behavioural reference model.
module tb_io_clk_sequencer;
    localparam int LOCK_TO  = 8;
    localparam int PAUSE_TO = 16;
`ifdef IO_CLK_SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    localparam int S_IDLE = 0, S_LOCK = 1, S_ACT = 2, S_PAUSE = 3, S_STOP = 4, S_FAULT = 5;
    localparam logic [1:0] C_START = 2'b00, C_PS = 2'b01, C_PL = 2'b10, C_STOP = 2'b11;

    // Expected vector layout: {state, gen, rec, pause, ready, fault, code, err}
    localparam logic [10:0] V_IDLE  = {3'b000, 5'b00000, 2'b00, 1'b0};
    localparam logic [10:0] V_LOCK  = {3'b001, 5'b10000, 2'b00, 1'b0};
    localparam logic [10:0] V_ACT   = {3'b010, 5'b11010, 2'b00, 1'b0};
    localparam logic [10:0] V_PAUSE = {3'b011, 5'b11100, 2'b00, 1'b0};
    localparam logic [10:0] V_STOP  = {3'b100, 5'b00000, 2'b00, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cmd_valid, lock, sc, lc, fv, dov, duv, clr;
    logic [1:0] cmd;
    logic       cmd_ready, gen_en, rec_en, pause_en, ready, fault, cmd_error;
    logic [1:0] fault_code;
    logic [2:0] state;
    logic [10:0] dut_vec;

    assign dut_vec = {state, gen_en, rec_en, pause_en, ready, fault, fault_code, cmd_error};

    io_clk_sequencer #(.Lock_Timeout(LOCK_TO), .Pause_Timeout(PAUSE_TO)) dut (
        .clk_i                      (clk),
        .rst_n_i                    (rst_n),
        .cmd_valid_i                (cmd_valid),
        .cmd_i                      (cmd),
        .cmd_ready_o                (cmd_ready),
        .clk_lock_i                 (lock),
        .short_pause_complete_i     (sc),
        .long_pause_complete_i      (lc),
        .frequency_violation_i      (fv),
        .data_overflow_violation_i  (dov),
        .data_underflow_violation_i (duv),
        .fault_clear_i              (clr),
        .generation_enable_o        (gen_en),
        .recovery_enable_o          (rec_en),
        .pause_enable_o             (pause_en),
        .ready_o                    (ready),
        .fault_o                    (fault),
        .fault_code_o               (fault_code),
        .cmd_error_o                (cmd_error),
        .state_o                    (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int         m_state;
    int         m_cnt;
    bit         m_long;
    logic [1:0] m_code;
    bit         m_err;

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt   = 0;
        m_long  = 1'b0;
        m_code  = 2'b00;
        m_err   = 1'b0;
    endtask

    function automatic logic [10:0] exp_vec();
        logic [2:0] s;
        logic g, r, p, rd, f;
        s  = 3'(m_state);
        g  = (m_state == S_LOCK) || (m_state == S_ACT) || (m_state == S_PAUSE);
        r  = (m_state == S_ACT) || (m_state == S_PAUSE);
        p  = (m_state == S_PAUSE);
        rd = (m_state == S_ACT);
        f  = (m_state == S_FAULT);
        return {s, g, r, p, rd, f, m_code, m_err};
    endfunction

    function automatic logic fault_vec_code(input logic [1:0] c);
        return 1'b0;
    endfunction

    // Advance one clock: derive the model's next state from the current
    // inputs, step the clock, then adopt it.
    task automatic tick();
        int ns, ncnt, lim;
        bit acc, viol, tmo, nlong, nerr, counting;
        logic [1:0] ncode;
        acc  = cmd_valid && (m_state == S_IDLE || m_state == S_LOCK || m_state == S_ACT);
        viol = fv || dov || duv;
        counting = (m_state == S_LOCK) || (m_state == S_PAUSE) || (m_state == S_STOP);
        lim  = (m_state == S_PAUSE) ? PAUSE_TO : LOCK_TO;
        tmo  = WD_ON && counting && (m_cnt >= lim - 1);
        ns = m_state; nlong = m_long; nerr = 1'b0;
        case (m_state)
            S_IDLE:  if (acc) begin
                         if (cmd == C_START) ns = S_LOCK;
                         else nerr = 1'b1;
                     end
            S_LOCK:  if (acc && cmd == C_STOP) ns = S_STOP;
                     else begin
                         nerr = acc;
                         if (lock) ns = S_ACT;
                         else if (tmo) ns = S_FAULT;
                     end
            S_ACT:   begin
                         nerr = acc && (cmd == C_START);
                         if (viol) ns = S_FAULT;
                         else if (acc && cmd == C_STOP) ns = S_STOP;
                         else if (acc && (cmd == C_PS || cmd == C_PL)) begin
                             ns = S_PAUSE;
                             nlong = (cmd == C_PL);
                         end else if (!lock) ns = S_LOCK;
                     end
            S_PAUSE: if (viol) ns = S_FAULT;
                     else if (m_long ? lc : sc) ns = S_ACT;
                     else if (tmo) ns = S_FAULT;
            S_STOP:  if (!lock) ns = S_IDLE;
                     else if (tmo) ns = S_FAULT;
            S_FAULT: if (clr) ns = S_IDLE;
            default: ns = S_IDLE;
        endcase
        if (ns != S_FAULT) ncode = 2'b00;
        else if (m_state == S_FAULT) ncode = m_code;
        else if ((m_state == S_ACT || m_state == S_PAUSE) && viol) ncode = fv ? 2'b10 : 2'b11;
        else ncode = 2'b01;
        if (ns != m_state) ncnt = 0;
        else if (counting) ncnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        else ncnt = m_cnt;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_state = ns; m_cnt = ncnt; m_long = nlong; m_code = ncode; m_err = nerr;
        end
    endtask

    task automatic quiet_inputs();
        cmd_valid = 1'b0; cmd = C_START; sc = 1'b0; lc = 1'b0;
        fv = 1'b0; dov = 1'b0; duv = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lock = 1'b0;
        quiet_inputs();
        model_reset();
        tick(); tick();
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL reset_outputs: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_start_lock();
        cmd_valid = 1'b1; cmd = C_START; lock = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (dut_vec !== V_LOCK) $display("FAIL locking_cycle%0d: got %b required %b", i, dut_vec, V_LOCK);
            else n_pass++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL locking_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
        lock = 1'b1;
        tick();
        n_checks++;
        if (dut_vec !== V_ACT) $display("FAIL lock_to_active: got %b required %b", dut_vec, V_ACT);
        else n_pass++;
        $display("test_start_lock done");
    endtask

    task automatic test_pause_long();
        cmd_valid = 1'b1; cmd = C_PL;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (dut_vec !== V_PAUSE) $display("FAIL pause_entry: got %b required %b", dut_vec, V_PAUSE);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL pausing_cmd_ready: got %b required 0", cmd_ready);
        else n_pass++;
        sc = 1'b1;
        tick();
        sc = 1'b0;
        n_checks++;
        if (dut_vec !== V_PAUSE) $display("FAIL short_pulse_ignored: got %b required %b", dut_vec, V_PAUSE);
        else n_pass++;
        lc = 1'b1;
        tick();
        lc = 1'b0;
        n_checks++;
        if (dut_vec !== V_ACT) $display("FAIL long_pulse_resume: got %b required %b", dut_vec, V_ACT);
        else n_pass++;
        $display("test_pause_long done");
    endtask

    task automatic test_violation_priority();
        logic [10:0] exp;
        cmd_valid = 1'b1; cmd = C_STOP; fv = 1'b1; dov = 1'b1;
        tick();
        quiet_inputs();
        exp = {3'b101, 5'b00001, 2'b10, 1'b0};
        n_checks++;
        if (dut_vec !== exp) $display("FAIL freq_over_stop: got %b required %b", dut_vec, exp);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL fault_cmd_ready: got %b required 0", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd = C_START;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (dut_vec !== exp) $display("FAIL fault_hold: got %b required %b", dut_vec, exp);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL fault_clear: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        cmd_valid = 1'b1; cmd = C_START;
        tick();
        cmd_valid = 1'b0;
        tick();
        duv = 1'b1;
        tick();
        duv = 1'b0;
        exp = {3'b101, 5'b00001, 2'b11, 1'b0};
        n_checks++;
        if (dut_vec !== exp) $display("FAIL data_code: got %b required %b", dut_vec, exp);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        $display("test_violation_priority done");
    endtask

    task automatic test_illegal_cmd();
        logic [10:0] exp;
        cmd_valid = 1'b1; cmd = C_PS;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
        tick();
        cmd_valid = 1'b0;
        exp = {3'b000, 5'b00000, 2'b00, 1'b1};
        n_checks++;
        if (dut_vec !== exp) $display("FAIL cmd_error_pulse: got %b required %b", dut_vec, exp);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL cmd_error_one_cycle: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL clear_in_idle: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        $display("test_illegal_cmd done");
    endtask

    task automatic test_watchdog();
        logic [10:0] exp;
        lock = 1'b0;
        cmd_valid = 1'b1; cmd = C_START;
        tick();
        cmd_valid = 1'b0;
`ifdef IO_CLK_SEQ_WATCHDOG_EN
        for (int i = 1; i < LOCK_TO; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== V_LOCK) $display("FAIL wdog_locking%0d: got %b required %b", i, dut_vec, V_LOCK);
            else n_pass++;
        end
        tick();
        exp = {3'b101, 5'b00001, 2'b01, 1'b0};
        n_checks++;
        if (dut_vec !== exp) $display("FAIL wdog_timeout: got %b required %b", dut_vec, exp);
        else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cmd_valid = 1'b1; cmd = C_START;
        tick();
        cmd_valid = 1'b0;
`else
        exp = V_LOCK;
        for (int i = 0; i < 40; i++) tick();
        n_checks++;
        if (dut_vec !== exp) $display("FAIL no_wdog_waits: got %b required %b", dut_vec, exp);
        else n_pass++;
`endif
        cmd_valid = 1'b1; cmd = C_STOP;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (dut_vec !== V_STOP) $display("FAIL stop_from_locking: got %b required %b", dut_vec, V_STOP);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL stopping_to_idle: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        $display("test_watchdog done");
    endtask

    task automatic test_async_reset();
        lock = 1'b1;
        cmd_valid = 1'b1; cmd = C_START;
        tick();
        cmd_valid = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd = C_PS;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (dut_vec !== V_PAUSE) $display("FAIL pre_reset_pausing: got %b required %b", dut_vec, V_PAUSE);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== V_IDLE) $display("FAIL async_reset_outputs: got %b required %b", dut_vec, V_IDLE);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        bit exp_ready;
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) lock = ~lock;
            sc  = ($urandom_range(0, 5) == 0);
            lc  = ($urandom_range(0, 5) == 0);
            fv  = ($urandom_range(0, 59) == 0);
            dov = ($urandom_range(0, 59) == 0);
            duv = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            if (!rst_n) model_reset();
            #1;
            exp_ready = (m_state == S_IDLE) || (m_state == S_LOCK) || (m_state == S_ACT);
            n_checks++;
            if (cmd_ready !== exp_ready) begin
                $display("FAIL rand_cmd_ready[%0d]: got %b required %b", i, cmd_ready, exp_ready);
                errs++;
            end else n_pass++;
            tick();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL rand_outputs[%0d]: got %b required %b", i, dut_vec, exp_vec());
                errs++;
            end else n_pass++;
        end
        rst_n = 1'b1;
        quiet_inputs();
        $display("test_random done, %0d mismatching cycles", errs);
    endtask

    initial begin
        test_reset();
        test_start_lock();
        test_pause_long();
        test_violation_priority();
        test_illegal_cmd();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
